rle_result_encoder: RTL and testbench

- Downstream of the IO/loader block on the result path. It consumes the 32-bit result words the IO block drives out (X vectors and the header word) and packs them into the same run-length nibble format the loader decodes on input.
- Output word format: 8 nibbles, MSB nibble first. Per nibble: bit[3] = bit value, bits[2:0] = run length 0..7. A run length of 0 is padding and is ignored by the decoder.
- Host-facing output uses a valid/ready handshake with a last flag, so the host link carries compressed results symmetric to the load path.

---
 rtl/rle_pkg.sv | 11 +
 rtl/rle_result_encoder_packer.sv | 32 +++
 rtl/rle_result_encoder.sv | 85 ++++++++
 tb/tb_rle_result_encoder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// rle_pkg: shared run-length nibble format used by the result encoder and the loader decoder.
package rle_pkg;
    localparam int RUN_W = 3;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam int NIB_PER_WORD = 8;
    typedef struct packed {
        logic             val;
        logic [RUN_W-1:0] len;
    } nibble_t;
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, EMIT} state_t;
endpackage

// File: rtl/rle_result_encoder_packer.sv
// rle_nibble_packer: collects committed nibbles MSB slot first; unwritten slots stay zero as padding.
module rle_nibble_packer
    import rle_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_commit,
    input  nibble_t           i_nib,
    input  logic              i_clear,
    output logic [WORD_W-1:0] o_data,
    output logic              o_fill,
    output logic              o_empty
);
    localparam int NIB = WORD_W / 4;
    localparam int CW  = $clog2(NIB) + 1;
    logic [CW-1:0]     r_cnt;
    logic [WORD_W-1:0] r_acc;
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_commit) begin
            r_acc[WORD_W-1-4*r_cnt -: 4] <= i_nib;
            r_cnt                        <= r_cnt + 1'b1;
        end
    end
    assign o_data  = r_acc;
    assign o_fill  = i_commit && (r_cnt == CW'(NIB - 1));
    assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/rle_result_encoder.sv
// rle_result_encoder: packs raw result words into run-length nibble words for the host link.
module rle_result_encoder
    import rle_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);
    localparam int PW = $clog2(WORD_W);
    state_t            r_state, r_ret;
    logic [WORD_W-1:0] r_word;
    logic              r_last, r_out_last;
    logic [PW-1:0]     r_ptr;
    nibble_t           r_run;
    logic              w_bit, w_ext, w_end, w_commit, w_fill, w_empty, w_clear;
    state_t            w_next;
    assign w_bit    = r_word[WORD_W-1-r_ptr];
    assign w_ext    = (r_run.len != '0) && (w_bit == r_run.val) && (r_run.len != RUN_MAX);
    assign w_end    = (r_ptr == PW'(WORD_W - 1));
    assign w_commit = (r_state == FLUSH) || ((r_state == SCAN) && (r_run.len != '0) && !w_ext);
    assign w_clear  = (r_state == EMIT) && out_ready;
    assign w_next   = w_end ? (r_last ? FLUSH : IDLE) : SCAN;
    rle_nibble_packer #(.WORD_W(WORD_W)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .i_commit (w_commit),
        .i_nib    (r_run),
        .i_clear  (w_clear),
        .o_data   (out_data),
        .o_fill   (w_fill),
        .o_empty  (w_empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ret      <= IDLE;
            r_word     <= '0;
            r_last     <= 1'b0;
            r_out_last <= 1'b0;
            r_ptr      <= '0;
            r_run      <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_word  <= in_data;
                    r_last  <= in_last;
                    r_ptr   <= '0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    // a committed run is replaced by the current bit, so EMIT can resume mid-word
                    r_run   <= w_ext ? nibble_t'{r_run.val, r_run.len + 1'b1} : nibble_t'{w_bit, RUN_W'(1)};
                    r_ptr   <= r_ptr + 1'b1;
                    r_ret   <= w_next;
                    r_state <= w_fill ? EMIT : w_next;
                end
                FLUSH: begin
                    r_run      <= '0;
                    r_last     <= 1'b0;
                    r_out_last <= 1'b1;
                    r_ret      <= IDLE;
                    r_state    <= EMIT;
                end
                EMIT: if (out_ready) begin
                    r_out_last <= 1'b0;
                    r_state    <= r_ret;
                end
            endcase
        end
    end
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE) || (r_run.len != '0) || !w_empty;
endmodule

// File: tb/tb_rle_result_encoder.sv
// tb_rle_result_encoder: directed vectors with hand-computed RLE outputs.
module tb_rle_result_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          lat;

    always #5 clk = ~clk;

    rle_result_encoder #(.WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [31:0] exp, input logic el, output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, el});
        @(negedge clk);
    endtask

    task automatic idle_check(input string tag);
        repeat (40) @(negedge clk);
        chk({tag, "_no_extra"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // all zeros: runs 7,7,7,7,4 then padding
        send(32'h0000_0000, 1'b1);
        chk("zero_in_ready_low", {31'd0, in_ready}, 32'd0);
        recv("zero", 32'h7777_4000, 1'b1, lat);
        chk("zero_latency", lat, 32'd33);
        idle_check("zero");

        // alternating bits, first word held off for 10 cycles
        out_ready = 1'b0;
        send(32'hAAAA_AAAA, 1'b1);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", out_data, 32'h9191_9191);
            chk("hold_last", {31'd0, out_last}, 32'd0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        recv("alt1", 32'h9191_9191, 1'b0, lat);
        recv("alt2", 32'h9191_9191, 1'b0, lat);
        recv("alt3", 32'h9191_9191, 1'b1, lat);
        idle_check("alt");

        // runs spanning a word boundary
        send(32'h0000_FFFF, 1'b0);
        lat = 0;
        while (!in_ready && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("span_pending_busy", {31'd0, busy}, 32'd1);
        chk("span_no_output", {31'd0, out_valid}, 32'd0);
        send(32'hFFFF_0000, 1'b1);
        recv("span1", 32'h772F_FFFC, 1'b0, lat);
        recv("span2", 32'h7720_0000, 1'b1, lat);
        idle_check("span");

        // reset mid-SCAN of the second word discards everything pending
        send(32'h1234_5678, 1'b0);
        send(32'h0F0F_0F0F, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        send(32'hFFFF_FFFF, 1'b1);
        recv("ones", 32'hFFFF_C000, 1'b1, lat);
        idle_check("ones");

        // runs 1,30,1: single one, 7+7+7+7+2 zeros, single one
        send(32'h8000_0001, 1'b1);
        recv("edge", 32'h9777_7290, 1'b1, lat);
        idle_check("edge");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
